// File: rtl/beam_steering.sv
// Stereo stimulus generator: one mono stream in, left/right out with a steering-controlled inter-channel delay.
// Latency 1 cycle from sample_valid to out_valid; no backpressure, a sample is accepted on every strobe.
module beam_steering #(
   parameter int DATA_WIDTH  = 16,
   parameter int window_size = 30
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] sample_in,
   input  logic                  sample_valid,
   input  logic [5:0]            steer_index,
   input  logic                  steer_load,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] left_data_out,
   output logic [DATA_WIDTH-1:0] right_data_out,
   output logic                  out_valid,
   output logic                  primed,
   output logic                  steer_error
);

   localparam int DEPTH = window_size + 1;
   localparam int PW    = $clog2(DEPTH);
   localparam int IW    = 6;

   typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_PRIMED} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_mem [0:window_size];
   logic [PW-1:0]         r_wp;
   logic [PW-1:0]         r_fill;
   logic [IW-1:0]         r_index;
   logic [DATA_WIDTH-1:0] r_left;
   logic [DATA_WIDTH-1:0] r_right;
   logic                  r_out_valid;
   logic                  r_primed;
   logic                  r_steer_error;

   logic [PW-1:0]         w_dly_l;
   logic [PW-1:0]         w_dly_r;
   logic [DATA_WIDTH-1:0] w_left;
   logic [DATA_WIDTH-1:0] w_right;
   logic                  w_load_ok;
   logic                  w_accept;
   logic                  w_fill_full;

   // Ring depth is window_size+1, not a power of two, so wrap explicitly.
   function automatic logic [PW-1:0] f_addr(input logic [PW-1:0] wp, input logic [PW-1:0] d);
      logic [PW:0] sum;
      if (wp >= d) sum = {1'b0, wp} - {1'b0, d};
      else         sum = {1'b0, wp} + (PW+1)'(DEPTH) - {1'b0, d};
      return sum[PW-1:0];
   endfunction

   always_comb begin
      w_dly_l = '0;
      w_dly_r = '0;
      if (r_index <= IW'(window_size)) w_dly_r = PW'(IW'(window_size) - r_index);
      else                             w_dly_l = PW'(r_index - IW'(window_size));
   end

   // Taps deeper than the fill count read as zero, so the memory never needs clearing.
   always_comb begin
      w_left  = '0;
      w_right = '0;
      if (w_dly_l == '0)          w_left = sample_in;
      else if (w_dly_l <= r_fill) w_left = r_mem[f_addr(r_wp, w_dly_l)];
      if (w_dly_r == '0)          w_right = sample_in;
      else if (w_dly_r <= r_fill) w_right = r_mem[f_addr(r_wp, w_dly_r)];
   end

   assign w_load_ok   = ({1'b0, steer_index} < 7'(2 * window_size));
   assign w_accept    = sample_valid && !flush;
   assign w_fill_full = (r_fill >= PW'(window_size - 1));

   always_ff @(posedge clk) begin
      if (w_accept) r_mem[r_wp] <= sample_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_EMPTY;
         r_wp          <= '0;
         r_fill        <= '0;
         r_index       <= IW'(window_size);
         r_left        <= '0;
         r_right       <= '0;
         r_out_valid   <= 1'b0;
         r_primed      <= 1'b0;
         r_steer_error <= 1'b0;
      end else begin
         r_out_valid   <= 1'b0;
         r_steer_error <= 1'b0;
         if (steer_load) begin
            if (w_load_ok) r_index       <= steer_index;
            else           r_steer_error <= 1'b1;
         end
         if (flush) begin
            r_state  <= S_EMPTY;
            r_wp     <= '0;
            r_fill   <= '0;
            r_primed <= 1'b0;
         end else if (sample_valid) begin
            r_left      <= w_left;
            r_right     <= w_right;
            r_out_valid <= 1'b1;
            r_wp        <= (r_wp == PW'(window_size)) ? '0 : r_wp + 1'b1;
            if (r_fill != PW'(window_size)) r_fill <= r_fill + 1'b1;
            case (r_state)
               S_EMPTY: begin
                  r_state  <= w_fill_full ? S_PRIMED : S_FILLING;
                  r_primed <= w_fill_full;
               end
               S_FILLING: begin
                  if (w_fill_full) begin
                     r_state  <= S_PRIMED;
                     r_primed <= 1'b1;
                  end
               end
               default: r_primed <= 1'b1;
            endcase
         end
      end
   end

   assign left_data_out  = r_left;
   assign right_data_out = r_right;
   assign out_valid      = r_out_valid;
   assign primed         = r_primed;
   assign steer_error    = r_steer_error;

endmodule

// File: tb/tb_beam_steering.sv
// Bench for beam_steering: reference model of the delay taps feeds a scoreboard queue checked on out_valid.
module tb_beam_steering;

   localparam int DW = 16;
   localparam int WS = 30;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] sample_in;
   logic          sample_valid;
   logic [5:0]    steer_index;
   logic          steer_load;
   logic          flush;
   logic [DW-1:0] left_data_out;
   logic [DW-1:0] right_data_out;
   logic          out_valid;
   logic          primed;
   logic          steer_error;

   beam_steering #(.DATA_WIDTH(DW), .window_size(WS)) dut (
      .clk            (clk),
      .reset          (reset),
      .sample_in      (sample_in),
      .sample_valid   (sample_valid),
      .steer_index    (steer_index),
      .steer_load     (steer_load),
      .flush          (flush),
      .left_data_out  (left_data_out),
      .right_data_out (right_data_out),
      .out_valid      (out_valid),
      .primed         (primed),
      .steer_error    (steer_error)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] hist [$];
   logic [31:0]   exp_q [$];
   int            m_idx;
   logic [DW-1:0] last_l;
   logic [DW-1:0] last_r;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // x[n-d] from the full stream since the last clear; zero if not yet seen.
   function automatic logic [DW-1:0] m_tap(input int d, input logic [DW-1:0] x);
      int c;
      int f;
      c = hist.size();
      f = (c > WS) ? WS : c;
      if (d == 0) return x;
      if (d > f) return '0;
      return hist[c - d];
   endfunction

   task automatic step(input logic v, input logic [DW-1:0] d, input logic ld,
                       input logic [5:0] si, input logic fl);
      int   a;
      int   b;
      logic exp_err;
      sample_valid = v;
      sample_in    = d;
      steer_load   = ld;
      steer_index  = si;
      flush        = fl;
      if (fl) begin
         hist.delete();
      end else if (v) begin
         a = (m_idx > WS) ? m_idx - WS : 0;
         b = (m_idx <= WS) ? WS - m_idx : 0;
         exp_q.push_back({m_tap(a, d), m_tap(b, d)});
         hist.push_back(d);
      end
      exp_err = ld && (si >= 6'(2 * WS));
      if (ld && !exp_err) m_idx = int'(si);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      steer_load   = 1'b0;
      flush        = 1'b0;
      check("steer_error", 32'(steer_error), 32'(exp_err));
      check("primed", 32'(primed), 32'(hist.size() >= WS));
   endtask

   task automatic ramp(input int base, input int n);
      for (int i = 1; i <= n; i++) step(1'b1, DW'(base + i), 1'b0, 6'd0, 1'b0);
   endtask

   task automatic load(input logic [5:0] si);
      step(1'b0, '0, 1'b1, si, 1'b0);
   endtask

   task automatic do_flush();
      step(1'b0, '0, 1'b0, 6'd0, 1'b1);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst_left", 32'(left_data_out), 32'd0);
      check("rst_right", 32'(right_data_out), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_primed", 32'(primed), 32'd0);
      check("rst_err", 32'(steer_error), 32'd0);
      check("rst_pending", 32'(exp_q.size()), 32'd0);
      hist.delete();
      exp_q.delete();
      m_idx  = WS;
      last_l = '0;
      last_r = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               check("left", 32'(left_data_out), 32'(e[31:16]));
               check("right", 32'(right_data_out), 32'(e[15:0]));
               last_l = e[31:16];
               last_r = e[15:0];
            end
         end else begin
            check("hold_left", 32'(left_data_out), 32'(last_l));
            check("hold_right", 32'(right_data_out), 32'(last_r));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      sample_in    = '0;
      sample_valid = 1'b0;
      steer_index  = '0;
      steer_load   = 1'b0;
      flush        = 1'b0;
      m_idx        = WS;
      last_l       = '0;
      last_r       = '0;
      do_reset();

      ramp(0, 40);                       // centre index: left = right = input
      load(6'd20); do_flush(); ramp(0, 100);
      load(6'd45); do_flush(); ramp(0, 60);
      load(6'd0);  do_flush(); ramp(0, 80);

      load(6'd60);                       // rejected, index stays 0
      ramp(500, 5);
      step(1'b1, 16'd200, 1'b1, 6'd25, 1'b0);
      ramp(300, 10);

      load(6'd10); do_flush(); ramp(0, 39);
      step(1'b1, 16'd40, 1'b0, 6'd0, 1'b1);   // flush beats the sample
      ramp(1000, 40);

      ramp(2000, 20);
      do_reset();
      load(6'd10);
      ramp(3000, 35);

      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, DW'($urandom), ($urandom % 8) == 0,
              6'($urandom % 64), ($urandom % 60) == 0);
      end
      step(1'b0, '0, 1'b0, 6'd0, 1'b0);
      step(1'b0, '0, 1'b0, 6'd0, 1'b0);
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
